// File: rtl/sys_bus_arb_if.sv
// System-bus bundle around the arbiter: NM master ports on one side, one slave port on the other.
// The arbiter itself uses the slave modport; the master modport is the surrounding environment.
interface sys_bus_arb_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_wen;
  logic [NM-1:0]    m_ren;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_ack;
  logic [NM-1:0]    m_err;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_wen;
  logic             s_ren;
  logic [DW-1:0]    s_rdata;
  logic             s_ack;
  logic             s_err;

  modport slave (
    input  m_addr, m_wdata, m_wen, m_ren, s_rdata, s_ack, s_err,
    output m_rdata, m_ack, m_err, s_addr, s_wdata, s_wen, s_ren
  );

  modport master (
    output m_addr, m_wdata, m_wen, m_ren, s_rdata, s_ack, s_err,
    input  m_rdata, m_ack, m_err, s_addr, s_wdata, s_wen, s_ren
  );
endinterface

// File: rtl/sys_bus_arb.sv
// Round-robin arbiter: NM system-bus masters share one slave port, one-deep request slot per
// master, a single outstanding slave access, and a watchdog that converts a missing ack into err.
module sys_bus_arb #(
  parameter int unsigned NM    = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned TMO   = 1024,
  parameter int unsigned FLUSH = 16
) (
  input logic          clk,
  input logic          rstn,
  sys_bus_arb_if.slave bus
);
  localparam int unsigned IW   = $clog2(NM);
  localparam int unsigned CMAX = (TMO > FLUSH) ? TMO : FLUSH;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NM-1:0]   pend_q, pend_d;
  logic [AW-1:0]   slot_addr_q  [NM];
  logic [AW-1:0]   slot_addr_d  [NM];
  logic [DW-1:0]   slot_wdata_q [NM];
  logic [DW-1:0]   slot_wdata_d [NM];
  logic [NM-1:0]   slot_we_q, slot_we_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic            s_wen_q, s_wen_d;
  logic            s_ren_q, s_ren_d;
  logic [DW-1:0]   m_rdata_q, m_rdata_d;
  logic [NM-1:0]   m_ack_q, m_ack_d;
  logic [NM-1:0]   m_err_q, m_err_d;
  logic            found, done;
  logic [IW-1:0]   gnt, cand;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    pend_d       = pend_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_we_d    = slot_we_q;
    s_addr_d     = s_addr_q;
    s_wdata_d    = s_wdata_q;
    s_wen_d      = 1'b0;
    s_ren_d      = 1'b0;
    m_rdata_d    = m_rdata_q;
    m_ack_d      = '0;
    m_err_d      = m_err_q;
    done         = 1'b0;
    found        = 1'b0;
    gnt          = last_q;
    cand         = '0;

    for (int unsigned k = 1; k <= NM; k++) begin
      cand = IW'((32'(last_q) + k) % NM);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end

    // In WAIT/FLUSH last_q is the slot being served.
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          s_addr_d  = slot_addr_q[gnt];
          s_wdata_d = slot_wdata_q[gnt];
          s_wen_d   = slot_we_q[gnt];
          s_ren_d   = !slot_we_q[gnt];
          last_d    = gnt;
          cnt_d     = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.s_ack) begin
          m_rdata_d       = slot_we_q[last_q] ? '0 : bus.s_rdata;
          m_ack_d[last_q] = 1'b1;
          m_err_d[last_q] = bus.s_err;
          done            = 1'b1;
          state_d         = ST_IDLE;
        end else if (cnt_q == CW'(TMO - 1)) begin
          m_rdata_d       = DW'(32'hDEADBEEF);
          m_ack_d[last_q] = 1'b1;
          m_err_d[last_q] = 1'b1;
          done            = 1'b1;
          cnt_d           = '0;
          state_d         = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == CW'(FLUSH - 1)) state_d = ST_IDLE;
        else                         cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion clears first so a strobe on the same edge re-arms the slot.
    for (int unsigned i = 0; i < NM; i++) begin
      if (done && (last_q == IW'(i))) pend_d[i] = 1'b0;
      if ((bus.m_wen[i] || bus.m_ren[i]) && !pend_d[i]) begin
        pend_d[i]       = 1'b1;
        slot_addr_d[i]  = bus.m_addr[i*AW +: AW];
        slot_wdata_d[i] = bus.m_wdata[i*DW +: DW];
        slot_we_d[i]    = bus.m_wen[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= IW'(NM - 1);
      pend_q       <= '0;
      slot_addr_q  <= '{default: '0};
      slot_wdata_q <= '{default: '0};
      slot_we_q    <= '0;
      s_addr_q     <= '0;
      s_wdata_q    <= '0;
      s_wen_q      <= 1'b0;
      s_ren_q      <= 1'b0;
      m_rdata_q    <= '0;
      m_ack_q      <= '0;
      m_err_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      pend_q       <= pend_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_we_q    <= slot_we_d;
      s_addr_q     <= s_addr_d;
      s_wdata_q    <= s_wdata_d;
      s_wen_q      <= s_wen_d;
      s_ren_q      <= s_ren_d;
      m_rdata_q    <= m_rdata_d;
      m_ack_q      <= m_ack_d;
      m_err_q      <= m_err_d;
    end
  end

  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign bus.s_wen   = s_wen_q;
  assign bus.s_ren   = s_ren_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.m_ack   = m_ack_q;
  assign bus.m_err   = m_err_q;
endmodule

// File: tb/tb_sys_bus_arb.sv
// Directed bench for sys_bus_arb: queued expectations for slave strobes and master acks,
// a programmable slave responder, and explicit timing checks.
module tb_sys_bus_arb;
  localparam int unsigned NM = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sys_bus_arb_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();
  sys_bus_arb #(.NM(NM), .AW(AW), .DW(DW), .TMO(TMO), .FLUSH(16)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct { int m; logic err; logic [DW-1:0] rdata; } mexp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } sexp_t;
  mexp_t mq[$];
  sexp_t sq[$];
  logic [DW-1:0] rdq[$];

  int checks = 0, errors = 0;
  int cyc = 0, req_cyc = 0, sstb_cyc = 0, mack_cyc = 0, sstb_cnt = 0, mack_cnt = 0;
  int ack_dly = 2, ack_cnt = 0;
  logic armed = 1'b0, is_rd = 1'b0, stray = 1'b0, serr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void exp_m(int m, logic err, logic [DW-1:0] rd);
    mexp_t e;
    e.m = m; e.err = err; e.rdata = rd;
    mq.push_back(e);
  endfunction

  function automatic void exp_s(logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    sexp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    sq.push_back(e);
  endfunction

  task automatic set_m(int m, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.m_addr[m*AW +: AW]  = a;
    bus.m_wdata[m*DW +: DW] = d;
  endtask

  task automatic pulse(logic [NM-1:0] w, logic [NM-1:0] r);
    @(negedge clk);
    bus.m_wen = w; bus.m_ren = r; req_cyc = cyc;
    @(negedge clk);
    bus.m_wen = '0; bus.m_ren = '0;
  endtask

  task automatic drain(string tag, int maxc);
    int n = 0;
    while ((mq.size() + sq.size()) != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(mq.size() + sq.size()), 64'd0);
  endtask

  task automatic check_outs_zero(string tag);
    check({tag, "_m_ack"},   64'(bus.m_ack),   64'd0);
    check({tag, "_m_err"},   64'(bus.m_err),   64'd0);
    check({tag, "_m_rdata"}, 64'(bus.m_rdata), 64'd0);
    check({tag, "_s_addr"},  64'(bus.s_addr),  64'd0);
    check({tag, "_s_wdata"}, 64'(bus.s_wdata), 64'd0);
    check({tag, "_s_wen"},   64'(bus.s_wen),   64'd0);
    check({tag, "_s_ren"},   64'(bus.s_ren),   64'd0);
  endtask

  // Scoreboard: every slave strobe and master ack must match the head of its queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.s_wen || bus.s_ren) begin
        sexp_t se;
        sstb_cnt++; sstb_cyc = cyc;
        check("s_strobe_expected", 64'(sq.size() > 0), 64'd1);
        if (sq.size() > 0) begin
          se = sq.pop_front();
          check("s_wen", 64'(bus.s_wen), 64'(se.we));
          check("s_ren", 64'(bus.s_ren), 64'(!se.we));
          check("s_addr", 64'(bus.s_addr), 64'(se.addr));
          if (se.we) check("s_wdata", 64'(bus.s_wdata), 64'(se.wdata));
        end
      end
      if (|bus.m_ack) begin
        mexp_t me;
        mack_cnt++; mack_cyc = cyc;
        check("m_ack_expected", 64'(mq.size() > 0), 64'd1);
        if (mq.size() > 0) begin
          me = mq.pop_front();
          check("m_ack", 64'(bus.m_ack), 64'(1) << me.m);
          check("m_err", 64'(bus.m_err[me.m]), 64'(me.err));
          check("m_rdata", 64'(bus.m_rdata), 64'(me.rdata));
        end
      end
    end
  end

  // Slave model: ack ack_dly cycles after a strobe (0 = same cycle, -1 = never).
  initial begin
    bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_rdata = '0;
    forever begin
      @(negedge clk);
      bus.s_ack = 1'b0; bus.s_err = 1'b0;
      if (rstn && (bus.s_wen || bus.s_ren) && ack_dly >= 0) begin
        armed = 1'b1; ack_cnt = ack_dly; is_rd = bus.s_ren;
      end
      if (armed) begin
        if (ack_cnt == 0) begin
          armed = 1'b0; bus.s_ack = 1'b1; bus.s_err = serr; serr = 1'b0;
          bus.s_rdata = 32'h0BAD0BAD;
          if (is_rd && rdq.size() > 0) bus.s_rdata = rdq.pop_front();
        end else begin
          ack_cnt--;
        end
      end
      if (stray) begin bus.s_ack = 1'b1; stray = 1'b0; end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int t, n, rereq, snap_s, snap_m;
    logic m0_sent;
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_wen = '0; bus.m_ren = '0;
    repeat (3) @(negedge clk);
    check_outs_zero("reset");
    rstn = 1'b1;

    // Single write, slave acks 2 cycles after s_wen.
    ack_dly = 2;
    set_m(0, 32'h40000010, 32'h12345678);
    exp_s(1'b1, 32'h40000010, 32'h12345678);
    exp_m(0, 1'b0, '0);
    pulse(2'b01, 2'b00);
    drain("t1_drain", 30);
    check("t1_strobe_lat", 64'(sstb_cyc - req_cyc), 64'd2);
    check("t1_ack_lat", 64'(mack_cyc - req_cyc), 64'd5);

    // Simultaneous reads right after reset: master 0 first.
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk); rstn = 1'b1;
    set_m(0, 32'h100, 32'h0); set_m(1, 32'h200, 32'h0);
    rdq.push_back(32'hA5A5A5A5); rdq.push_back(32'h5A5A5A5A);
    exp_s(1'b0, 32'h100, '0); exp_s(1'b0, 32'h200, '0);
    exp_m(0, 1'b0, 32'hA5A5A5A5); exp_m(1, 1'b0, 32'h5A5A5A5A);
    pulse(2'b00, 2'b11);
    drain("t2_drain", 40);

    // Round-robin: master 1 re-requests on each completion, master 0 once.
    ack_dly = 1;
    exp_s(1'b0, 32'h300, '0); exp_s(1'b0, 32'h310, '0);
    exp_s(1'b0, 32'h320, '0); exp_s(1'b0, 32'h330, '0);
    rdq.push_back(32'h11); rdq.push_back(32'h22); rdq.push_back(32'h33); rdq.push_back(32'h44);
    exp_m(1, 1'b0, 32'h11); exp_m(0, 1'b0, 32'h22);
    exp_m(1, 1'b0, 32'h33); exp_m(1, 1'b0, 32'h44);
    set_m(1, 32'h300, '0);
    pulse(2'b00, 2'b10);
    n = 0; rereq = 0; m0_sent = 1'b0;
    while (mq.size() > 0 && n < 100) begin
      @(negedge clk); #1; n++;
      bus.m_ren = '0;
      if (!m0_sent && bus.s_ren) begin
        set_m(0, 32'h310, '0); bus.m_ren[0] = 1'b1; m0_sent = 1'b1;
      end
      if (bus.s_ack && bus.s_addr != 32'h310 && rereq < 2) begin
        set_m(1, (rereq == 0) ? 32'h320 : 32'h330, '0); bus.m_ren[1] = 1'b1; rereq++;
      end
    end
    bus.m_ren = '0;
    drain("t3_drain", 20);

    // Timeout: slave never acks master 1's read; a late stray ack is ignored.
    ack_dly = -1;
    set_m(1, 32'h500, '0);
    exp_s(1'b0, 32'h500, '0);
    exp_m(1, 1'b1, 32'hDEADBEEF);
    pulse(2'b00, 2'b10);
    drain("t4_drain", 40);
    check("t4_tmo_lat", 64'(mack_cyc - sstb_cyc), 64'(TMO));
    t = mack_cyc; snap_m = mack_cnt;
    while (cyc < t + 2) @(negedge clk);
    #1 stray = 1'b1;
    repeat (6) @(negedge clk);
    check("t4_stray_no_ack", 64'(mack_cnt - snap_m), 64'd0);
    ack_dly = 0;
    set_m(0, 32'h40000020, 32'hCAFEF00D);
    exp_s(1'b1, 32'h40000020, 32'hCAFEF00D);
    exp_m(0, 1'b0, '0);
    pulse(2'b01, 2'b00);
    drain("t4_after_drain", 60);

    // Busy plus violation: only master 0's first write reaches the slave.
    ack_dly = 4; serr = 1'b1;
    rdq.push_back(32'h66666666);
    exp_s(1'b0, 32'h600, '0); exp_s(1'b1, 32'h604, 32'h1111AAAA);
    exp_m(1, 1'b1, 32'h66666666); exp_m(0, 1'b0, '0);
    set_m(1, 32'h600, '0);
    pulse(2'b00, 2'b10);
    set_m(0, 32'h604, 32'h1111AAAA);
    pulse(2'b01, 2'b00);
    set_m(0, 32'h608, 32'h2222BBBB);
    pulse(2'b01, 2'b00);
    drain("t5_drain", 60);
    repeat (5) @(negedge clk);
    check("t5_one_write", 64'(sq.size() + mq.size()), 64'd0);

    // Async reset while in WAIT with master 1 pending.
    ack_dly = 5;
    set_m(0, 32'h700, 32'h77777777);
    exp_s(1'b0, 32'h700, '0);
    pulse(2'b00, 2'b01);
    set_m(1, 32'h704, '0);
    pulse(2'b00, 2'b10);
    #2 rstn = 1'b0;
    #1 check_outs_zero("async_rst");
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    snap_s = sstb_cnt; snap_m = mack_cnt;
    repeat (20) @(negedge clk);
    check("t6_no_strobe", 64'(sstb_cnt - snap_s), 64'd0);
    check("t6_no_ack", 64'(mack_cnt - snap_m), 64'd0);
    drain("final_drain", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
